// File: rtl/minmax_ctrl_pkg.sv
// Shared types for the min/max search controller: FSM states, comparator flags
// and the signed/unsigned condition decode applied to those flags.
package minmax_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    CMP_MIN,
    CMP_MAX,
    DONE
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // a < b from the flags of a-b
  function automatic logic flags_lt(input flags_t f, input logic signed_mode);
    return signed_mode ? (f.n ^ f.v) : ~f.c;
  endfunction

  // a > b from the flags of a-b
  function automatic logic flags_gt(input flags_t f, input logic signed_mode);
    return signed_mode ? (~f.z & ~(f.n ^ f.v)) : (f.c & ~f.z);
  endfunction

endpackage

// File: rtl/cmp_flag_unit.sv
// Combinational subtract-based comparator producing ALU-style n/z/c/v flags of a-b.
module cmp_flag_unit
  import minmax_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output flags_t           flags_o
);

  logic [WIDTH-1:0] diff;
  logic             borrow;

  // The extra top bit of the widened subtraction is the borrow out.
  assign {borrow, diff} = {1'b0, a_i} - {1'b0, b_i};

  assign flags_o.n = diff[WIDTH-1];
  assign flags_o.z = (diff == '0);
  assign flags_o.c = ~borrow;
  assign flags_o.v = ((a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (a_i[WIDTH-1] ^ diff[WIDTH-1]));

endmodule

// File: rtl/minmax_search_controller.sv
// Streams a batch of samples through one shared comparator, tracking the running
// minimum and maximum together with the index of the first occurrence of each.
module minmax_search_controller
  import minmax_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int COUNT_MAX = 16,
  localparam int CNT_W    = $clog2(COUNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [CNT_W-1:0] length,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] min_value,
  output logic [WIDTH-1:0] max_value,
  output logic [CNT_W-1:0] min_index,
  output logic [CNT_W-1:0] max_index
);

  state_t           state_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic             signed_q;
  logic [CNT_W-1:0] length_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [WIDTH-1:0] sample_q;
  logic [CNT_W-1:0] sample_idx_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [CNT_W-1:0] min_idx_q;
  logic [CNT_W-1:0] max_idx_q;

  logic [WIDTH-1:0] cmp_b;
  flags_t           flags;
  logic             length_bad;

  assign count_d    = count_q + CNT_W'(1);
  assign length_bad = (length == '0) || (length > CNT_W'(COUNT_MAX));

  // One comparator serves both passes; the state picks which running value it sees.
  assign cmp_b = (state_q == CMP_MAX) ? max_q : min_q;

  cmp_flag_unit #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a_i    (sample_q),
    .b_i    (cmp_b),
    .flags_o(flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      signed_q     <= 1'b0;
      length_q     <= '0;
      count_q      <= '0;
      sample_q     <= '0;
      sample_idx_q <= '0;
      min_q        <= '0;
      max_q        <= '0;
      min_idx_q    <= '0;
      max_idx_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            signed_q <= signed_mode;
            length_q <= length;
            busy_q   <= 1'b1;
            if (length_bad) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              error_q    <= 1'b0;
              count_q    <= '0;
              in_ready_q <= 1'b1;
              state_q    <= ACCEPT;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            sample_q     <= in_data;
            sample_idx_q <= count_q;
            count_q      <= count_d;
            if (count_q == '0) begin
              // First sample seeds both running values; no compare needed.
              min_q     <= in_data;
              max_q     <= in_data;
              min_idx_q <= '0;
              max_idx_q <= '0;
              if (length_q == CNT_W'(1)) begin
                in_ready_q <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= DONE;
              end
            end else begin
              in_ready_q <= 1'b0;
              state_q    <= CMP_MIN;
            end
          end
        end
        CMP_MIN: begin
          if (flags_lt(flags, signed_q)) begin
            min_q     <= sample_q;
            min_idx_q <= sample_idx_q;
          end
          state_q <= CMP_MAX;
        end
        CMP_MAX: begin
          if (flags_gt(flags, signed_q)) begin
            max_q     <= sample_q;
            max_idx_q <= sample_idx_q;
          end
          if (count_q == length_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ACCEPT;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign min_value = min_q;
  assign max_value = max_q;
  assign min_index = min_idx_q;
  assign max_index = max_idx_q;

endmodule
